// File: rtl/uart_pkt_pkg.sv
// Shared definitions for the UART command-packet path: parser states, the default
// start byte and the command codes understood by the LCD/sensor control logic.
package uart_pkt_pkg;

   typedef enum logic [2:0] {
      S_HUNT = 3'd0,
      S_CMD  = 3'd1,
      S_LEN  = 3'd2,
      S_DATA = 3'd3,
      S_CHK  = 3'd4,
      S_OUT  = 3'd5
   } state_e;

   localparam logic [7:0] SYNC_DEFAULT = 8'hAA;

   localparam logic [7:0] CMD_LCD_WR  = 8'h01;
   localparam logic [7:0] CMD_LCD_CLR = 8'h02;
   localparam logic [7:0] CMD_DHT_RD  = 8'h10;

endpackage

// File: rtl/uart_fifo_reader.sv
// Paces reads from the RX FIFO: one ren pulse, then the byte is presented the following
// cycle; no new read is issued until that byte has been consumed.
module uart_fifo_reader (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_rvalid,
   input  logic [7:0] i_rdata,
   input  logic       i_hold,
   output logic       o_ren,
   output logic       o_byte_vld,
   output logic [7:0] o_byte
);

   logic r_ren;
   logic r_byte_vld;

   // ren and byte_vld gate each other, giving at least 3 cycles per byte so a FIFO that
   // is just going empty is never read twice on a stale rvalid.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_ren      <= 1'b0;
         r_byte_vld <= 1'b0;
      end else begin
         r_ren      <= i_rvalid & ~r_ren & ~r_byte_vld & ~i_hold;
         r_byte_vld <= r_ren;
      end
   end

   assign o_ren      = r_ren;
   assign o_byte_vld = r_byte_vld;
   assign o_byte     = i_rdata;

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles SYNC/CMD/LEN/PAYLOAD/CHK packets from the RX FIFO and presents checksum-valid
// commands on a valid/ready port; malformed packets are dropped with a one-cycle error pulse.
module uart_cmd_parser
   import uart_pkt_pkg::*;
#(
   parameter int unsigned MAX_LEN = 4,
   parameter logic [15:0] TIMEOUT = 16'd50000,
   parameter logic [7:0]  SYNC    = SYNC_DEFAULT
) (
   input  logic                   mclk,
   input  logic                   reset,
   input  logic                   rvalid,
   input  logic [7:0]             rdata,
   output logic                   ren,
   output logic                   cmd_valid,
   input  logic                   cmd_ready,
   output logic [7:0]             cmd_code,
   output logic [3:0]             cmd_len,
   output logic [8*MAX_LEN-1:0]   cmd_data,
   output logic                   chk_err,
   output logic                   len_err,
   output logic                   to_err,
   output logic [7:0]             pkt_cnt
);

   localparam logic [7:0] MaxLenByte = 8'(MAX_LEN);

   state_e               r_state;
   logic [7:0]           r_code;
   logic [7:0]           r_chk;
   logic [3:0]           r_len;
   logic [3:0]           r_idx;
   logic [8*MAX_LEN-1:0] r_buf;
   logic [15:0]          r_to_cnt;
   logic                 r_cmd_valid;
   logic [7:0]           r_cmd_code;
   logic [3:0]           r_cmd_len;
   logic [8*MAX_LEN-1:0] r_cmd_data;
   logic                 r_chk_err;
   logic                 r_len_err;
   logic                 r_to_err;
   logic [7:0]           r_pkt_cnt;

   logic       w_byte_vld;
   logic [7:0] w_byte;
   logic       w_hold;
   logic       w_in_pkt;
   logic       w_to_hit;

   assign w_hold   = (r_state == S_OUT);
   assign w_in_pkt = (r_state == S_CMD) || (r_state == S_LEN) ||
                     (r_state == S_DATA) || (r_state == S_CHK);
   // A byte landing on the terminal count wins over the timeout.
   assign w_to_hit = w_in_pkt && !w_byte_vld && (r_to_cnt == TIMEOUT);

   uart_fifo_reader u_reader (
      .i_clk      (mclk),
      .i_reset    (reset),
      .i_rvalid   (rvalid),
      .i_rdata    (rdata),
      .i_hold     (w_hold),
      .o_ren      (ren),
      .o_byte_vld (w_byte_vld),
      .o_byte     (w_byte)
   );

   always_ff @(posedge mclk) begin
      if (reset) begin
         r_state     <= S_HUNT;
         r_code      <= '0;
         r_chk       <= '0;
         r_len       <= '0;
         r_idx       <= '0;
         r_buf       <= '0;
         r_to_cnt    <= '0;
         r_cmd_valid <= 1'b0;
         r_cmd_code  <= '0;
         r_cmd_len   <= '0;
         r_cmd_data  <= '0;
         r_chk_err   <= 1'b0;
         r_len_err   <= 1'b0;
         r_to_err    <= 1'b0;
         r_pkt_cnt   <= '0;
      end else begin
         r_chk_err <= 1'b0;
         r_len_err <= 1'b0;
         r_to_err  <= 1'b0;

         if (!w_in_pkt || w_byte_vld) begin
            r_to_cnt <= '0;
         end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
         end

         if (w_to_hit) begin
            r_to_err <= 1'b1;
            r_state  <= S_HUNT;
         end else begin
            case (r_state)
               S_HUNT: begin
                  if (w_byte_vld && (w_byte == SYNC)) r_state <= S_CMD;
               end
               S_CMD: begin
                  if (w_byte_vld) begin
                     r_code  <= w_byte;
                     r_chk   <= w_byte;
                     r_state <= S_LEN;
                  end
               end
               S_LEN: begin
                  if (w_byte_vld) begin
                     if (w_byte > MaxLenByte) begin
                        r_len_err <= 1'b1;
                        r_state   <= S_HUNT;
                     end else begin
                        r_len   <= w_byte[3:0];
                        r_chk   <= r_chk ^ w_byte;
                        r_idx   <= '0;
                        r_buf   <= '0;
                        r_state <= (w_byte == 8'd0) ? S_CHK : S_DATA;
                     end
                  end
               end
               S_DATA: begin
                  if (w_byte_vld) begin
                     for (int unsigned i = 0; i < MAX_LEN; i++) begin
                        if (r_idx == 4'(i)) r_buf[8*i +: 8] <= w_byte;
                     end
                     r_chk <= r_chk ^ w_byte;
                     r_idx <= r_idx + 4'd1;
                     if (r_idx == (r_len - 4'd1)) r_state <= S_CHK;
                  end
               end
               S_CHK: begin
                  if (w_byte_vld) begin
                     if (w_byte == r_chk) begin
                        r_cmd_valid <= 1'b1;
                        r_cmd_code  <= r_code;
                        r_cmd_len   <= r_len;
                        r_cmd_data  <= r_buf;
                        r_state     <= S_OUT;
                     end else begin
                        r_chk_err <= 1'b1;
                        r_state   <= S_HUNT;
                     end
                  end
               end
               S_OUT: begin
                  if (r_cmd_valid && cmd_ready) begin
                     r_cmd_valid <= 1'b0;
                     r_pkt_cnt   <= r_pkt_cnt + 8'd1;
                     r_state     <= S_HUNT;
                  end
               end
               default: r_state <= S_HUNT;
            endcase
         end
      end
   end

   assign cmd_valid = r_cmd_valid;
   assign cmd_code  = r_cmd_code;
   assign cmd_len   = r_cmd_len;
   assign cmd_data  = r_cmd_data;
   assign chk_err   = r_chk_err;
   assign len_err   = r_len_err;
   assign to_err    = r_to_err;
   assign pkt_cnt   = r_pkt_cnt;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: a FIFO model feeds bytes, a packet-level reference
// model predicts events, and a monitor compares every command and error pulse in order.
module tb_uart_cmd_parser;
   import uart_pkt_pkg::*;

   localparam int unsigned MAX_LEN = 4;
   localparam int          TO_CYC  = 20;
   localparam int          DW      = 8 * MAX_LEN;
   localparam int EV_CMD = 0, EV_CHK = 1, EV_LEN = 2, EV_TO = 3;

   typedef struct {
      int            kind;
      logic [7:0]    code;
      logic [3:0]    len;
      logic [DW-1:0] data;
   } ev_t;

   logic          mclk = 1'b0;
   logic          reset = 1'b1;
   logic          rvalid = 1'b0;
   logic [7:0]    rdata = 8'h00;
   logic          cmd_ready = 1'b0;
   logic          ren, cmd_valid, chk_err, len_err, to_err;
   logic [7:0]    cmd_code, pkt_cnt;
   logic [3:0]    cmd_len;
   logic [DW-1:0] cmd_data;

   ev_t        exp_q[$];
   logic [7:0] mq[$];
   logic [7:0] fifo_q[$];
   int n_checks = 0, n_pass = 0;
   int cyc = 0, last_pop_cyc = 0, acc_cnt = 0, ready_mode = 0;

   uart_cmd_parser #(
      .MAX_LEN (MAX_LEN),
      .TIMEOUT (16'(TO_CYC)),
      .SYNC    (SYNC_DEFAULT)
   ) dut (
      .mclk      (mclk),
      .reset     (reset),
      .rvalid    (rvalid),
      .rdata     (rdata),
      .ren       (ren),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_code  (cmd_code),
      .cmd_len   (cmd_len),
      .cmd_data  (cmd_data),
      .chk_err   (chk_err),
      .len_err   (len_err),
      .to_err    (to_err),
      .pkt_cnt   (pkt_cnt)
   );

   always #5 mclk = ~mclk;

   initial forever begin
      @(posedge mclk);
      cyc++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference model: scan the byte stream for complete packets by the framing rules.
   task automatic model_run();
      int            len;
      logic [7:0]    x;
      logic [DW-1:0] d;
      ev_t           e;
      while (1) begin
         while (mq.size() > 0 && mq[0] != SYNC_DEFAULT) void'(mq.pop_front());
         if (mq.size() < 3) return;
         len = int'(mq[2]);
         e.code = 8'h00; e.len = 4'h0; e.data = '0;
         if (len > int'(MAX_LEN)) begin
            e.kind = EV_LEN;
            exp_q.push_back(e);
            repeat (3) void'(mq.pop_front());
            continue;
         end
         if (mq.size() < 4 + len) return;
         x = mq[1] ^ mq[2];
         d = '0;
         for (int i = 0; i < len; i++) begin
            d[8*i +: 8] = mq[3+i];
            x = x ^ mq[3+i];
         end
         if (mq[3+len] == x) begin
            e.kind = EV_CMD; e.code = mq[1]; e.len = 4'(len); e.data = d;
         end else begin
            e.kind = EV_CHK;
         end
         exp_q.push_back(e);
         repeat (4 + len) void'(mq.pop_front());
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      fifo_q.push_back(b);
      rvalid = 1'b1;
      mq.push_back(b);
   endtask

   task automatic send_now(input int n, input logic [127:0] v);
      for (int i = 0; i < n; i++) push_byte(v[8*(n-1-i) +: 8]);
      model_run();
   endtask

   task automatic send(input int n, input logic [127:0] v);
      @(negedge mclk);
      send_now(n, v);
   endtask

   // Upstream FIFO: data appears the cycle after ren.
   initial forever begin
      @(negedge mclk);
      if (ren) begin
         check("fifo_nonempty_on_ren", 64'(fifo_q.size() != 0), 64'd1);
         if (fifo_q.size() != 0) rdata = fifo_q.pop_front();
         last_pop_cyc = cyc;
         rvalid = (fifo_q.size() != 0);
      end
   end

   // Monitor: drives cmd_ready, then checks whatever the DUT presents this cycle.
   initial forever begin
      ev_t e;
      int  kind_obs;
      @(negedge mclk);
      case (ready_mode)
         0:       cmd_ready = 1'b1;
         1:       cmd_ready = 1'($urandom_range(0, 1));
         default: cmd_ready = 1'b0;
      endcase
      if (!reset) begin
         if (chk_err || len_err || to_err) begin
            check("err_onehot", 64'($countones({chk_err, len_err, to_err})), 64'd1);
            kind_obs = chk_err ? EV_CHK : (len_err ? EV_LEN : EV_TO);
            check("err_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("err_kind", 64'(kind_obs), 64'(e.kind));
            end
         end
         if (cmd_valid) check("no_ren_in_out", 64'(ren), 64'd0);
         if (cmd_valid && cmd_ready) begin
            check("cmd_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("cmd_kind", 64'(EV_CMD), 64'(e.kind));
               check("cmd_code", 64'(cmd_code), 64'(e.code));
               check("cmd_len", 64'(cmd_len), 64'(e.len));
               check("cmd_data", 64'(cmd_data), 64'(e.data));
            end
            check("pkt_cnt", 64'(pkt_cnt), 64'(acc_cnt % 256));
            acc_cnt++;
         end
      end
   end

   task automatic wait_drain(input string name);
      int n = 0;
      while ((fifo_q.size() != 0 || exp_q.size() != 0 || cmd_valid) && n < 3000) begin
         @(negedge mclk);
         n++;
      end
      check(name, 64'(n < 3000), 64'd1);
      repeat (4) @(negedge mclk);
   endtask

   task automatic wait_fifo_empty();
      int n = 0;
      while (fifo_q.size() != 0 && n < 200) begin
         @(negedge mclk);
         n++;
      end
   endtask

   task automatic test_timeout();
      int n = 0;
      ev_t e;
      send(2, 128'hAA01);
      e.kind = EV_TO; e.code = 8'h00; e.len = 4'h0; e.data = '0;
      exp_q.push_back(e);
      mq.delete();
      wait_fifo_empty();
      while (!to_err && n < 100) begin
         @(negedge mclk);
         n++;
      end
      // ren cycle -> byte_vld next cycle -> count reaches TIMEOUT -> registered pulse.
      check("to_latency", 64'(cyc - last_pop_cyc), 64'(TO_CYC + 3));
      wait_drain("to_drain");
      // Next byte's byte_vld lands exactly on to_cnt == TIMEOUT: no error.
      send(2, 128'hAA01);
      wait_fifo_empty();
      n = 0;
      while (cyc < last_pop_cyc + TO_CYC && n < 100) begin
         @(negedge mclk);
         n++;
      end
      send_now(2, 128'h0001);
      wait_drain("to_boundary_drain");
   endtask

   task automatic test_backpressure();
      int n = 0;
      ready_mode = 2;
      send(6, 128'hAA0102414200);
      send_now(4, 128'hAA020002);
      while (!cmd_valid && n < 200) begin
         @(negedge mclk);
         n++;
      end
      check("bp_valid_seen", 64'(cmd_valid), 64'd1);
      repeat (100) begin
         @(negedge mclk);
         check("bp_hold", 64'({cmd_valid, ren, cmd_code, cmd_len, cmd_data}),
               64'({1'b1, 1'b0, 8'h01, 4'h2, 32'h0000_4241}));
      end
      ready_mode = 0;
      wait_drain("bp_drain");
   endtask

   task automatic test_reset_mid();
      send(5, 128'hAA01031122);
      wait_fifo_empty();
      repeat (3) @(negedge mclk);
      reset = 1'b1;
      @(negedge mclk);
      check("rst_mid_outputs", 64'({ren, cmd_valid, cmd_code, cmd_len, cmd_data,
                                    chk_err, len_err, to_err, pkt_cnt}), 64'd0);
      mq.delete();
      acc_cnt = 0;
      reset = 1'b0;
      repeat (2) @(negedge mclk);
   endtask

   task automatic rand_pkt();
      logic [7:0] b[$];
      logic [7:0] x, code;
      int len;
      int kind = int'($urandom_range(0, 9));
      repeat ($urandom_range(0, 2)) begin
         x = 8'($urandom_range(0, 255));
         if (x == SYNC_DEFAULT) x = 8'h55;
         b.push_back(x);
      end
      case ($urandom_range(0, 3))
         0:       code = CMD_LCD_WR;
         1:       code = CMD_LCD_CLR;
         2:       code = CMD_DHT_RD;
         default: code = 8'($urandom_range(0, 255));
      endcase
      b.push_back(SYNC_DEFAULT);
      b.push_back(code);
      if (kind == 0) begin
         b.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
      end else begin
         len = int'($urandom_range(0, MAX_LEN));
         b.push_back(8'(len));
         x = code ^ 8'(len);
         for (int i = 0; i < len; i++) begin
            b.push_back(8'($urandom_range(0, 255)));
            x = x ^ b[b.size()-1];
         end
         if (kind == 1) x = x ^ 8'($urandom_range(1, 255));
         b.push_back(x);
      end
      foreach (b[i]) push_byte(b[i]);
      model_run();
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed",
               n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      repeat (3) @(negedge mclk);
      check("rst_outputs", 64'({ren, cmd_valid, cmd_code, cmd_len, cmd_data,
                                chk_err, len_err, to_err, pkt_cnt}), 64'd0);
      reset = 1'b0;

      send(6, 128'hAA0102414200);
      wait_drain("t1_drain");
      check("t1_pkt_cnt", 64'(pkt_cnt), 64'd1);

      send(6, 128'h5500AA020002);
      wait_drain("t2_drain");
      check("t2_pkt_cnt", 64'(pkt_cnt), 64'd2);

      send(5, 128'hAA01013300);
      send_now(4, 128'hAA100010);
      wait_drain("t3_drain");
      check("t3_pkt_cnt", 64'(pkt_cnt), 64'd3);

      send(3, 128'hAA0105);
      send_now(4, 128'hAA020002);
      wait_drain("t4_drain");
      check("t4_pkt_cnt", 64'(pkt_cnt), 64'd4);

      test_timeout();
      test_backpressure();
      test_reset_mid();

      ready_mode = 1;
      for (int p = 0; p < 60; p++) begin
         @(negedge mclk);
         rand_pkt();
         repeat ($urandom_range(0, 30)) @(negedge mclk);
      end
      ready_mode = 0;
      wait_drain("rand_drain");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
